// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with saturating stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IMEM_BUSY_WAIT,
  input  logic             DMEM_BUSY_WAIT,
  input  logic             BRANCH_RES,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [2:0]       EX_MEM_READ,
  input  logic [4:0]       EX_RD,
  input  logic             EX_REG_WRITE,
  input  logic             CNT_CLR,
  output logic             PC_HOLD,
  output logic             IFID_HOLD,
  output logic             IFID_FLUSH,
  output logic             IDEX_HOLD,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_BUSY_WAIT,
  output logic             MEMWB_HOLD,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);
  logic             lu, fl, a_dm, a_fl, a_lu, a_im, fp_d, fp_q;
  logic [2:0]       state_d, state_q;
  logic [CNT_W-1:0] stall_d, stall_q, flush_d, flush_q;
  always_comb begin
    lu = (EX_MEM_READ != 3'd0) && EX_REG_WRITE && (EX_RD != 5'd0) &&
         ((ID_RS1_USED && ID_RS1 == EX_RD) || (ID_RS2_USED && ID_RS2 == EX_RD));
    fl = BRANCH_RES | fp_q;
    a_dm = RESET & DMEM_BUSY_WAIT;
    a_fl = RESET & ~DMEM_BUSY_WAIT & fl;
    a_lu = RESET & ~DMEM_BUSY_WAIT & ~fl & lu;
    a_im = RESET & ~DMEM_BUSY_WAIT & ~fl & ~lu & IMEM_BUSY_WAIT;
    state_d = a_dm ? 3'd1 : a_fl ? 3'd2 : a_lu ? 3'd3 : a_im ? 3'd4 : 3'd0;
    fp_d = a_dm & fl;
    stall_d = CNT_CLR ? '0 : ((a_dm | a_lu | a_im) && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = CNT_CLR ? '0 : (a_fl && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    PC_HOLD = a_dm | a_lu | a_im;
    IFID_HOLD = a_dm | a_lu;
    IFID_FLUSH = ~RESET | a_fl | a_im;
    IDEX_HOLD = a_dm;
    IDEX_FLUSH = ~RESET | a_fl | a_lu;
    EXMEM_BUSY_WAIT = a_dm;
    MEMWB_HOLD = a_dm;
    STATE = state_q;
    STALL_CNT = stall_q;
    FLUSH_CNT = flush_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= 3'd0;
      fp_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fp_q <= fp_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, imem, dmem, br, rs1_used, rs2_used, ex_wr, cnt_clr;
  logic [4:0] rs1, rs2, ex_rd;
  logic [2:0] ex_rd_code;
  logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_bw, memwb_hold;
  logic [2:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .CLK(clk), .RESET(rst_n), .IMEM_BUSY_WAIT(imem), .DMEM_BUSY_WAIT(dmem), .BRANCH_RES(br),
    .ID_RS1(rs1), .ID_RS2(rs2), .ID_RS1_USED(rs1_used), .ID_RS2_USED(rs2_used),
    .EX_MEM_READ(ex_rd_code), .EX_RD(ex_rd), .EX_REG_WRITE(ex_wr), .CNT_CLR(cnt_clr),
    .PC_HOLD(pc_hold), .IFID_HOLD(ifid_hold), .IFID_FLUSH(ifid_flush), .IDEX_HOLD(idex_hold),
    .IDEX_FLUSH(idex_flush), .EXMEM_BUSY_WAIT(exmem_bw), .MEMWB_HOLD(memwb_hold),
    .STATE(state), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );
  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_bw, memwb_hold};
  localparam logic [6:0] C_RUN = 7'b0000000, C_RST = 7'b0010100, C_DM = 7'b1101011,
                         C_FL = 7'b0010100, C_LU = 7'b1100100, C_IM = 7'b1010000;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    imem = 0; dmem = 0; br = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    ex_rd_code = 0; ex_rd = 0; ex_wr = 0; cnt_clr = 0;
  endtask
  task automatic set_lu;
    ex_rd_code = 3'b010; ex_wr = 1; ex_rd = 5; rs2 = 5; rs2_used = 1;
  endtask
  initial begin
    rst_n = 0;
    imem = 1; dmem = 1; br = 1; rs1 = '1; rs2 = '1; rs1_used = 1; rs2_used = 1;
    ex_rd_code = '1; ex_rd = '1; ex_wr = 1; cnt_clr = 1;
    #2;
    for (int i = 0; i < 2; i++) begin
      #2 check("rst_ctl", ctl, C_RST);
      tick;
    end
    idle;
    rst_n = 1;
    #2;
    check("rst_state", state, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    check("run_ctl", ctl, C_RUN);
    set_lu;
    #2 check("lu_ctl", ctl, C_LU);
    tick;
    idle;
    check("lu_state", state, 3);
    check("lu_stall", stall_cnt, 1);
    set_lu;
    ex_rd = 0; rs2 = 0;
    #2 check("x0_ctl", ctl, C_RUN);
    tick;
    check("x0_state", state, 0);
    check("x0_stall", stall_cnt, 1);
    set_lu;
    rs2_used = 0; rs1 = 5;
    #2 check("rs1_unused_ctl", ctl, C_RUN);
    rs1_used = 1;
    #1 check("rs1_lu_ctl", ctl, C_LU);
    ex_rd_code = 0;
    #1 check("noload_ctl", ctl, C_RUN);
    idle;
    cnt_clr = 1;
    tick;
    idle;
    check("clr_stall", stall_cnt, 0);
    dmem = 1; br = 1;
    for (int i = 0; i < 3; i++) begin
      #2 check("dmbr_ctl", ctl, C_DM);
      tick;
      br = 0;
      check("dmbr_state", state, 1);
    end
    dmem = 0;
    #2 check("dflush_ctl", ctl, C_FL);
    tick;
    check("dflush_state", state, 2);
    #2 check("dflush_once", ctl, C_RUN);
    tick;
    check("dmbr_flushcnt", flush_cnt, 1);
    check("dmbr_stallcnt", stall_cnt, 3);
    imem = 1;
    for (int i = 0; i < 4; i++) begin
      #2 check("im_ctl", ctl, C_IM);
      tick;
      check("im_state", state, 4);
    end
    imem = 0;
    check("im_stall", stall_cnt, 7);
    br = 1; imem = 1; set_lu;
    #2 check("prio_ctl", ctl, C_FL);
    tick;
    check("prio_state", state, 2);
    check("prio_flushcnt", flush_cnt, 2);
    br = 0;
    #2 check("luim_ctl", ctl, C_LU);
    tick;
    check("luim_state", state, 3);
    idle;
    imem = 1;
    #2 check("im_after_lu", ctl, C_IM);
    tick;
    idle;
    dmem = 1; br = 1;
    tick;
    idle;
    rst_n = 0;
    tick;
    rst_n = 1;
    #2 check("rst_drop_fp", ctl, C_RUN);
    check("rst_drop_fcnt", flush_cnt, 0);
    dmem = 1;
    for (int i = 0; i < 20; i++) tick;
    check("sat_stall", stall_cnt, 15);
    cnt_clr = 1;
    tick;
    check("clr_busy_stall", stall_cnt, 0);
    cnt_clr = 0;
    tick;
    check("post_clr_stall", stall_cnt, 1);
    idle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Decides each cycle, from memory busy-waits, the taken-branch result latched in EX/MEM, and ID-vs-EX register comparison, which pipeline registers hold, which are squashed, and whether PC advances.
- Drives the BUSY_WAIT input of the EX/MEM pipeline register and the hold/flush inputs of the IF/ID, ID/EX and MEM/WB registers and the PC.
- Keeps saturating stall/flush counters for performance debug.

Parameters:
CNT_W, 16, width of STALL_CNT and FLUSH_CNT

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-low reset (sampled on posedge CLK, 0 = reset)
IMEM_BUSY_WAIT  in  1  instruction cache miss in progress
DMEM_BUSY_WAIT  in  1  data cache access in progress
BRANCH_RES  in  1  taken branch/jump, from EX/MEM register output
ID_RS1  in  5  rs1 of instruction in ID
ID_RS2  in  5  rs2 of instruction in ID
ID_RS1_USED  in  1  ID instruction reads rs1
ID_RS2_USED  in  1  ID instruction reads rs2
EX_MEM_READ  in  3  mem-read code of instruction in EX; nonzero = load
EX_RD  in  5  destination register of instruction in EX
EX_REG_WRITE  in  1  EX instruction writes rd
CNT_CLR  in  1  synchronous clear of both counters
PC_HOLD  out  1  PC keeps its value
IFID_HOLD  out  1  IF/ID register holds
IFID_FLUSH  out  1  IF/ID loads a NOP
IDEX_HOLD  out  1  ID/EX register holds
IDEX_FLUSH  out  1  ID/EX loads a bubble (all control 0)
EXMEM_BUSY_WAIT  out  1  EX/MEM register holds
MEMWB_HOLD  out  1  MEM/WB register holds
STATE  out  3  registered action of previous cycle
STALL_CNT  out  CNT_W  stall cycles
FLUSH_CNT  out  CNT_W  flush events

Behaviour:
- Control outputs are combinational from current inputs and flush_pending. Only STATE, flush_pending and the counters are registered.
- Load-use hazard LU = (EX_MEM_READ != 0) & EX_REG_WRITE & (EX_RD != 0) & ((ID_RS1_USED & ID_RS1 == EX_RD) | (ID_RS2_USED & ID_RS2 == EX_RD)).
- Fixed priority, exactly one action per cycle:
  1. DMEM_WAIT (DMEM_BUSY_WAIT=1): PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_BUSY_WAIT, MEMWB_HOLD = 1; no flushes. If BRANCH_RES=1, set flush_pending. STALL_CNT++.
  2. FLUSH (BRANCH_RES | flush_pending): IFID_FLUSH = IDEX_FLUSH = 1; all holds 0 (PC loads the branch target). Clear flush_pending. FLUSH_CNT++. LU and IMEM_BUSY_WAIT are ignored this cycle.
  3. LOAD_USE (LU): PC_HOLD = IFID_HOLD = 1, IDEX_FLUSH = 1; EX/MEM and MEM/WB advance. STALL_CNT++. Exactly one bubble, since the load has left EX next cycle.
  4. IMEM_WAIT (IMEM_BUSY_WAIT): PC_HOLD = 1, IFID_FLUSH = 1; downstream stages advance. STALL_CNT++.
  5. RUN: all outputs 0.
- STATE encoding: RUN=0, DMEM_WAIT=1, FLUSH=2, LOAD_USE=3, IMEM_WAIT=4. It registers the action chosen this cycle.
- Counters saturate at all-ones and never wrap. CNT_CLR has priority over increment in the same cycle.
- Reset (RESET=0 at posedge): STATE=RUN, flush_pending=0, STALL_CNT=FLUSH_CNT=0.
- While RESET=0: IFID_FLUSH = IDEX_FLUSH = 1, every other control output = 0.
- Reset asserted during a DMEM wait or with a pending flush discards the pending flush.
- Simultaneous events:
  - DMEM busy together with a branch: the flush is deferred, then issued exactly once in the first non-busy cycle, counted once.
  - IMEM busy together with LU: LOAD_USE wins; IMEM_WAIT is re-evaluated next cycle.
- EX_RD = x0 never causes a stall.

Test Plan:
- Reset: RESET=0 for 2 cycles with all inputs 1 -> IFID_FLUSH=IDEX_FLUSH=1, other controls 0; after release STATE=0, counters 0.
- Load-use: EX_MEM_READ=3'b010, EX_REG_WRITE=1, EX_RD=5, ID_RS2=5, ID_RS2_USED=1 for 1 cycle -> PC_HOLD=IFID_HOLD=IDEX_FLUSH=1, STATE=3 next cycle, STALL_CNT=1. Same with EX_RD=0 -> no stall.
- Branch during DMEM busy: BRANCH_RES=1 for 1 cycle while DMEM_BUSY_WAIT=1 for 3 cycles -> all holds 1 for 3 cycles, then one cycle IFID_FLUSH=IDEX_FLUSH=1; FLUSH_CNT=1, STALL_CNT=3.
- IMEM miss: IMEM_BUSY_WAIT=1 for 4 cycles -> PC_HOLD=IFID_FLUSH=1, EXMEM_BUSY_WAIT=0 each cycle; STATE=4; STALL_CNT=4.
- Priority: BRANCH_RES=1, LU true and IMEM_BUSY_WAIT=1 in the same cycle -> FLUSH only, PC_HOLD=0.
- Saturation: CNT_W=4, 20 DMEM-busy cycles -> STALL_CNT=15. Then CNT_CLR=1 together with busy -> STALL_CNT=0.
